// File: rtl/trigger_buffer.sv
// Edge-triggered capture buffer: circular RAM with programmable pre-trigger depth,
// read back oldest-first one sample per rd_en once the record is complete.
module trigger_buffer #(
   parameter int BITS_ADC  = 8,
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [BITS_ADC-1:0]  trig_level,
   input  logic                 trig_edge,
   input  logic [ADDR_BITS-1:0] pretrig,
   input  logic [BITS_ADC-1:0]  sample_in,
   input  logic                 rdy_in,
   input  logic                 rd_en,
   output logic [BITS_ADC-1:0]  sample_out,
   output logic                 rdy_out,
   output logic                 triggered,
   output logic                 done,
   output logic                 busy
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS:0] DEPTH_W = {1'b1, {ADDR_BITS{1'b0}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4,
      READ  = 3'd5
   } state_t;

   state_t               state_r;
   logic [BITS_ADC-1:0]  ram_r [0:DEPTH-1];
   logic [ADDR_BITS-1:0] wp_r;
   logic [ADDR_BITS-1:0] rd_ptr_r;
   logic [ADDR_BITS-1:0] rd_cnt_r;
   logic [ADDR_BITS:0]   cnt_r;
   logic [ADDR_BITS-1:0] pretrig_r;
   logic [BITS_ADC-1:0]  level_r;
   logic                 edge_r;
   logic [BITS_ADC-1:0]  prev_r;
   logic                 prev_valid_r;

   logic                 we_s;
   logic                 hit_s;
   logic [ADDR_BITS:0]   cnt_inc_s;
   logic [ADDR_BITS:0]   post_len_s;

   // Post-trigger length includes the trigger sample itself.
   assign cnt_inc_s  = cnt_r + 1'b1;
   assign post_len_s = DEPTH_W - {1'b0, pretrig_r};

   // RAM write enable: incoming samples are stored only while capturing.
   always_comb begin
      we_s = 1'b0;
      case (state_r)
         PRE, ARMED, POST: we_s = rdy_in;
         default:          we_s = 1'b0;
      endcase
   end

   // Edge detection against the latched level, unsigned full-width compare.
   always_comb begin
      hit_s = 1'b0;
      if (!prev_valid_r) begin
         hit_s = 1'b0;
      end else if (edge_r) begin
         hit_s = (prev_r >= level_r) && (sample_in < level_r);
      end else begin
         hit_s = (prev_r < level_r) && (sample_in >= level_r);
      end
   end

   // Sample storage write port; contents need no reset.
   always_ff @(posedge clk) begin
      if (we_s) begin
         ram_r[wp_r] <= sample_in;
      end
   end

   // Capture/readout controller with registered status and read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         wp_r         <= {ADDR_BITS{1'b0}};
         rd_ptr_r     <= {ADDR_BITS{1'b0}};
         rd_cnt_r     <= {ADDR_BITS{1'b0}};
         cnt_r        <= {(ADDR_BITS+1){1'b0}};
         pretrig_r    <= {ADDR_BITS{1'b0}};
         level_r      <= {BITS_ADC{1'b0}};
         edge_r       <= 1'b0;
         prev_r       <= {BITS_ADC{1'b0}};
         prev_valid_r <= 1'b0;
         sample_out   <= {BITS_ADC{1'b0}};
         rdy_out      <= 1'b0;
         triggered    <= 1'b0;
         done         <= 1'b0;
         busy         <= 1'b0;
      end else begin
         rdy_out <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  pretrig_r    <= pretrig;
                  level_r      <= trig_level;
                  edge_r       <= trig_edge;
                  cnt_r        <= {(ADDR_BITS+1){1'b0}};
                  wp_r         <= {ADDR_BITS{1'b0}};
                  prev_valid_r <= 1'b0;
                  busy         <= 1'b1;
                  state_r      <= (pretrig == {ADDR_BITS{1'b0}}) ? ARMED : PRE;
               end
            end
            PRE: begin
               if (rdy_in) begin
                  wp_r         <= wp_r + 1'b1;
                  cnt_r        <= cnt_inc_s;
                  prev_r       <= sample_in;
                  prev_valid_r <= 1'b1;
                  if (cnt_inc_s == {1'b0, pretrig_r}) begin
                     state_r <= ARMED;
                  end
               end
            end
            ARMED: begin
               if (rdy_in) begin
                  wp_r <= wp_r + 1'b1;
                  if (hit_s) begin
                     triggered <= 1'b1;
                     cnt_r     <= {{ADDR_BITS{1'b0}}, 1'b1};
                     // With pretrig = DEPTH-1 the trigger sample already completes the record.
                     if (post_len_s == {{ADDR_BITS{1'b0}}, 1'b1}) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                     end else begin
                        state_r <= POST;
                     end
                  end else begin
                     prev_r       <= sample_in;
                     prev_valid_r <= 1'b1;
                  end
               end
            end
            POST: begin
               if (rdy_in) begin
                  wp_r  <= wp_r + 1'b1;
                  cnt_r <= cnt_inc_s;
                  if (cnt_inc_s == post_len_s) begin
                     done    <= 1'b1;
                     state_r <= DONE;
                  end
               end
            end
            DONE: begin
               rd_ptr_r <= wp_r;
               rd_cnt_r <= {ADDR_BITS{1'b0}};
               state_r  <= READ;
            end
            READ: begin
               if (rd_en) begin
                  sample_out <= ram_r[rd_ptr_r];
                  rdy_out    <= 1'b1;
                  rd_ptr_r   <= rd_ptr_r + 1'b1;
                  rd_cnt_r   <= rd_cnt_r + 1'b1;
                  if (rd_cnt_r == {ADDR_BITS{1'b1}}) begin
                     state_r   <= IDLE;
                     busy      <= 1'b0;
                     done      <= 1'b0;
                     triggered <= 1'b0;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trigger_buffer.sv
// Scoreboard bench for trigger_buffer (ADDR_BITS=4): a reference model derives the
// expected record from the sample history; a monitor checks every readout strobe.
module tb_trigger_buffer;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] trig_level = 8'h00;
   logic       trig_edge = 1'b0;
   logic [3:0] pretrig = 4'd0;
   logic [7:0] sample_in = 8'h00;
   logic       rdy_in = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] sample_out;
   logic       rdy_out;
   logic       triggered;
   logic       done;
   logic       busy;

   logic       rd_window = 1'b0;
   logic       exp_rdy = 1'b0;
   logic [7:0] stim [$];
   logic [7:0] expq [$];
   int         n_total = 0;
   int         n_pass = 0;

   trigger_buffer #(.BITS_ADC(8), .ADDR_BITS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .trig_level(trig_level),
      .trig_edge(trig_edge), .pretrig(pretrig), .sample_in(sample_in),
      .rdy_in(rdy_in), .rd_en(rd_en), .sample_out(sample_out),
      .rdy_out(rdy_out), .triggered(triggered), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A read accepted on an edge must produce exactly one strobe after that edge.
   always @(posedge clk) exp_rdy <= rd_en && rd_window;

   // Monitor: every strobe pops the scoreboard.
   always @(negedge clk) begin
      if (rdy_out || exp_rdy) begin
         check("rdy_out", {31'd0, rdy_out}, {31'd0, exp_rdy});
         if (rdy_out) begin
            if (expq.size() == 0) check("spurious_rdy_out", {31'd0, rdy_out}, 32'd0);
            else check("sample_out", {24'd0, sample_out}, {24'd0, expq.pop_front()});
         end
      end
   end

   // Reference: prev is simply the preceding sample of the history, absent only for sample 0.
   function automatic int find_trig(input int pt, input logic edg, input logic [7:0] lvl);
      for (int i = pt; i < stim.size(); i++) begin
         if (i > 0) begin
            if (!edg && stim[i-1] < lvl && stim[i] >= lvl) return i;
            if (edg && stim[i-1] >= lvl && stim[i] < lvl) return i;
         end
      end
      return -1;
   endfunction

   task automatic run_capture(input int pt, input logic edg, input logic [7:0] lvl,
                              input int inj_rd, input int inj_start, input int abort_at);
      int t;
      int last;
      t    = find_trig(pt, edg, lvl);
      last = t + DEPTH - pt - 1;
      start = 1'b1; pretrig = 4'(pt); trig_edge = edg; trig_level = lvl;
      tick();
      start = 1'b0;
      pretrig = 4'($urandom); trig_edge = 1'($urandom); trig_level = 8'($urandom);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      for (int i = 0; i <= last; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         rdy_in = 1'b1; sample_in = stim[i];
         rd_en = (i == inj_rd); start = (i == inj_start);
         tick();
         rdy_in = 1'b0; rd_en = 1'b0; start = 1'b0;
         if (i == t - 1) check("triggered_before", {31'd0, triggered}, 32'd0);
         if (i == t) check("triggered_at_trig", {31'd0, triggered}, 32'd1);
         if (i == last - 1) check("done_early", {31'd0, done}, 32'd0);
         if (i == abort_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_triggered", {31'd0, triggered}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_rdy_out", {31'd0, rdy_out}, 32'd0);
            return;
         end
      end
      check("done_at_final", {31'd0, done}, 32'd1);
      for (int i = t - pt; i <= last; i++) expq.push_back(stim[i]);
      tick();
      for (int k = 0; k < DEPTH; k++) begin
         if (k > 0) begin
            repeat ($urandom_range(0, 2)) begin
               rdy_in = 1'($urandom); sample_in = 8'($urandom);
               tick();
            end
         end
         rd_en = 1'b1; rd_window = 1'b1; rdy_in = 1'($urandom); sample_in = 8'($urandom);
         tick();
         rd_en = 1'b0;
      end
      rd_window = 1'b0; rdy_in = 1'b0;
      check("busy_after_last_rd", {31'd0, busy}, 32'd0);
      check("done_cleared", {31'd0, done}, 32'd0);
      check("triggered_cleared", {31'd0, triggered}, 32'd0);
      // A stray read in IDLE must be ignored.
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
      check("scoreboard_drained", expq.size(), 32'd0);
   endtask

   task automatic make_ramp();
      stim.delete();
      for (int i = 0; i < 32; i++) stim.push_back(8'(i * 16));
   endtask

   initial begin
      int pt;
      logic edg;
      logic [7:0] lvl;
      repeat (3) tick();
      check("reset_sample_out", {24'd0, sample_out}, 32'd0);
      check("reset_rdy_out", {31'd0, rdy_out}, 32'd0);
      check("reset_triggered", {31'd0, triggered}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick();

      // Rising ramp, 4 pre-trigger samples.
      make_ramp();
      run_capture(4, 1'b0, 8'h80, -1, -1, -1);

      // Falling; first armed sample has no predecessor.
      stim.delete();
      stim.push_back(8'h20); stim.push_back(8'h50); stim.push_back(8'h30);
      for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
      run_capture(0, 1'b1, 8'h40, -1, -1, -1);

      // No pre-trigger: record starts at the trigger sample.
      stim.delete();
      stim.push_back(8'h10); stim.push_back(8'h90);
      for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
      run_capture(0, 1'b0, 8'h80, -1, -1, -1);

      // Maximum pre-trigger with pointer wrap.
      stim.delete();
      for (int i = 0; i < 40; i++) stim.push_back(8'($urandom_range(0, 127)));
      stim.push_back(8'hC0);
      run_capture(15, 1'b0, 8'h80, -1, -1, -1);

      // rd_en in ARMED and start in POST are ignored.
      stim.delete();
      stim.push_back(8'h10); stim.push_back(8'h20); stim.push_back(8'h30);
      stim.push_back(8'h40); stim.push_back(8'h45); stim.push_back(8'h60);
      for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
      run_capture(3, 1'b0, 8'h50, 4, 7, -1);

      // Reset mid-POST, then a clean capture.
      make_ramp();
      run_capture(2, 1'b0, 8'h80, -1, -1, 10);
      make_ramp();
      run_capture(2, 1'b0, 8'h80, -1, -1, -1);

      // Randomized captures.
      for (int r = 0; r < 4; r++) begin
         pt  = $urandom_range(0, 15);
         edg = 1'($urandom);
         lvl = 8'($urandom_range(1, 255));
         stim.delete();
         for (int i = 0; i < pt + int'($urandom_range(0, 10)); i++) stim.push_back(8'($urandom));
         if (edg) begin stim.push_back(8'hFF); stim.push_back(8'h00); end
         else begin stim.push_back(8'h00); stim.push_back(8'hFF); end
         for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
         run_capture(pt, edg, lvl, -1, -1, -1);
      end

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/trigger_buffer.md
# trigger_buffer

Capture stage placed directly downstream of `moving_average`. It consumes the decimated sample stream and performs edge triggering against a programmable level. Samples are stored in a circular on-chip buffer, with a programmable number of pre-trigger samples. Once the capture completes, the record is read out oldest-first, one sample per read request, toward the host interface.

## Interface
Parameters:
- `BITS_ADC`, 8, sample width; matches `moving_average` output width.
- `ADDR_BITS`, 8, buffer address width; DEPTH = 2^ADDR_BITS samples.

Ports:
- `clk`  in  1  fpga clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle pulse; arms a new capture
- `trig_level`  in  BITS_ADC  trigger threshold, unsigned
- `trig_edge`  in  1  0 = rising, 1 = falling
- `pretrig`  in  ADDR_BITS  number of pre-trigger samples kept (0..DEPTH-1)
- `sample_in`  in  BITS_ADC  sample from `moving_average`
- `rdy_in`  in  1  sample_in valid strobe (1 cycle)
- `rd_en`  in  1  read request, one sample per asserted cycle
- `sample_out`  out  BITS_ADC  readout data
- `rdy_out`  out  1  sample_out valid strobe
- `triggered`  out  1  high from trigger sample until return to IDLE
- `done`  out  1  record complete and readable
- `busy`  out  1  high in every state except IDLE

## Operation
- Buffer: simple dual-port RAM of DEPTH x BITS_ADC with a registered read port. Write pointer `wp` is ADDR_BITS wide and wraps naturally.
- States and transitions:
  - IDLE: `start` -> PRE, or -> ARMED if `pretrig` = 0. On `start`: latch `pretrig`, `trig_level` and `trig_edge`; clear `cnt`, `wp` and `prev_valid`.
  - PRE: each `rdy_in` writes RAM[wp], increments `wp`, increments `cnt`, and updates `prev`. When `cnt` reaches `pretrig` -> ARMED. The trigger is not evaluated in PRE.
  - ARMED: each `rdy_in` writes RAM[wp] and increments `wp` (overwriting the oldest data).
    - Rising trigger: `prev_valid` && `prev` < level && `sample_in` >= level.
    - Falling trigger: `prev_valid` && `prev` >= level && `sample_in` < level.
    - On trigger: the sample is written, `triggered` <= 1, `cnt` <= 1 (the trigger sample counts as the first post sample), -> POST.
    - Otherwise `prev` <= `sample_in` and `prev_valid` <= 1.
  - POST: each `rdy_in` writes and increments `cnt`. When `cnt` reaches DEPTH-`pretrig` (the write completing the record) -> DONE, with `done` <= 1.
  - DONE: `rd_ptr` <= `wp`, which is the oldest sample (trig_addr - pretrig mod DEPTH). `rd_cnt` <= 0. -> READ. `rdy_in` is ignored from here on.
  - READ: each `rd_en` reads RAM[rd_ptr], increments `rd_ptr` and increments `rd_cnt`. When the DEPTH-th read is issued -> IDLE, and `done` and `triggered` clear.
- `start` outside IDLE is ignored. `rd_en` outside READ is ignored and produces no `rdy_out`.
- Config inputs may change at any time; only the values latched at `start` are used.
- `prev_valid` is 0 after `start`. `prev` does carry from PRE into ARMED, so a crossing between the last PRE sample and the first ARMED sample triggers.
- Comparisons are unsigned and use the full BITS_ADC width.

## Timing
- Reset values: `sample_out`=0, `rdy_out`=0, `triggered`=0, `done`=0, `busy`=0, state IDLE, `wp`=0.
- Reset has priority over all inputs in the same cycle. Reset mid-capture or mid-readout aborts to IDLE on the next edge; RAM contents are don't-care.
- `busy` goes high the cycle after `start`.
- `rdy_in` to RAM write takes 0 cycles (written on that edge).
- `triggered` goes high on the edge that writes the trigger sample.
- `done` goes high on the edge that writes the final sample. The first `rd_en` is accepted 2 cycles after the final write edge (DONE -> READ).
- Read latency is 1 cycle: `rd_en` at edge n gives `sample_out` valid with `rdy_out`=1 at edge n+1. `rdy_out` is high for exactly 1 cycle per accepted read. `sample_out` holds between reads.
- Back-to-back `rd_en` sustains 1 sample per cycle.
- `busy` drops the cycle after the last read is issued; the last `rdy_out` appears in that same cycle.
- `rdy_in` and `rd_en` in the same cycle cannot conflict, because write and read states are disjoint.

## Test plan
- ADDR_BITS=4, `pretrig`=4, rising, level=0x80. Stimulus: ramp 0x00, 0x10, ... -> trigger on the sample 0x80. Reading 16 samples returns 0x40, 0x50, 0x60, 0x70, 0x80, ..., with `rdy_out` 1 cycle after each `rd_en`.
- Falling edge, level=0x40. Stimulus: the first ARMED sample is 0x20 (prev invalid), then 0x50, 0x30 -> trigger on 0x30, not on 0x20.
- `pretrig`=0. Stimulus: start then trigger -> the first read returns the trigger sample, and 16 reads return 16 consecutive samples.
- `pretrig`=15. Stimulus: 40 samples before the trigger -> reads return the 15 samples immediately preceding the trigger, then the trigger sample, verifying pointer wrap.
- `start` pulsed during POST and `rd_en` pulsed during ARMED -> both ignored, no `rdy_out`, and the record is unchanged.
- `rst` asserted mid-POST -> the next cycle shows `busy`=0, `triggered`=0, `done`=0, `rdy_out`=0. A new `start` then completes a full capture correctly.
